// File: rtl/math_pipelined_pkg.sv
// Shared definitions for the chunk-sliced pipelined ALU: op encodings and
// the width/latency arithmetic that sizes the chunk pipeline.
package math_pipelined_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  function automatic int f_AluWidth(int width, int latency);
    return (width + latency - 1) / latency;
  endfunction

  function automatic int f_ChunkCount(int width, int latency);
    int aw;
    aw = f_AluWidth(width, latency);
    return (width + aw - 1) / aw;
  endfunction

  // Only the top chunk can be narrower than the ALU slice width.
  function automatic int f_LastChunkSize(int width, int latency);
    return width - (f_ChunkCount(width, latency) - 1) * f_AluWidth(width, latency);
  endfunction

endpackage

// File: rtl/math_pipelined_chunk.sv
// Combinational CW-bit ALU slice; the top level registers everything around it.
module math_pipelined_chunk
  import math_pipelined_pkg::*;
#(
  parameter int CW = 1
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  input  logic [2:0]    op,
  output logic [CW-1:0] r,
  output logic          cout,
  output logic          zero
);

  logic [CW-1:0] b_eff;
  logic [CW:0]   sum;

  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{CW{1'b0}}, cin};
    r     = '0;
    cout  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        r    = sum[CW-1:0];
        cout = sum[CW];
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = a ^ b;
    endcase
  end

  assign zero = (r == '0);

endmodule

// File: rtl/math_pipelined_alu.sv
// Pipelined ALU: one ALU_WIDTH chunk per stage, carry registered between stages,
// operands skewed in and result chunks carried forward so all bits exit aligned.
module math_pipelined_alu
  import math_pipelined_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             i_valid,
  input  logic [2:0]       i_op,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_zero
);

  localparam int AW  = f_AluWidth(WIDTH, LATENCY);
  localparam int CC  = f_ChunkCount(WIDTH, LATENCY);
  localparam int LCS = f_LastChunkSize(WIDTH, LATENCY);

  logic             vld_q  [CC];
  logic             vld_d  [CC];
  logic [2:0]       op_q   [CC];
  logic [2:0]       op_d   [CC];
  logic             cy_q   [CC];
  logic             cy_d   [CC];
  logic             zero_q [CC];
  logic             zero_d [CC];
  logic [WIDTH-1:0] a_q    [CC];
  logic [WIDTH-1:0] a_d    [CC];
  logic [WIDTH-1:0] b_q    [CC];
  logic [WIDTH-1:0] b_d    [CC];
  logic [WIDTH-1:0] res_q  [CC];
  logic [WIDTH-1:0] res_d  [CC];
  logic             ovf_q;
  logic             ovf_d;

  logic             st_vld  [CC];
  logic [2:0]       st_op   [CC];
  logic             st_cin  [CC];
  logic             st_zero [CC];
  logic [WIDTH-1:0] st_a    [CC];
  logic [WIDTH-1:0] st_b    [CC];
  logic [WIDTH-1:0] st_res  [CC];

  logic [WIDTH-1:0] ch_r     [CC];
  logic             ch_cout  [CC];
  logic             ch_zero  [CC];

  // Stage 0 takes the ports directly; later stages take the previous stage's registers.
  always_comb begin : p_stage_in
    st_vld[0]  = i_valid;
    st_op[0]   = i_op;
    st_a[0]    = I1;
    st_b[0]    = I2;
    st_res[0]  = '0;
    st_zero[0] = 1'b1;
    case (i_op)
      OP_ADD:  st_cin[0] = i_cin;
      OP_SUB:  st_cin[0] = ~i_cin;
      default: st_cin[0] = 1'b0;
    endcase
    for (int k = 1; k < CC; k++) begin
      st_vld[k]  = vld_q[k-1];
      st_op[k]   = op_q[k-1];
      st_a[k]    = a_q[k-1];
      st_b[k]    = b_q[k-1];
      st_res[k]  = res_q[k-1];
      st_zero[k] = zero_q[k-1];
      st_cin[k]  = cy_q[k-1];
    end
  end

  for (genvar k = 0; k < CC; k++) begin : g_chunk
    localparam int CW = (k == CC - 1) ? LCS : AW;
    logic [CW-1:0] r;

    math_pipelined_chunk #(.CW(CW)) u_chunk (
      .a    (st_a[k][k*AW +: CW]),
      .b    (st_b[k][k*AW +: CW]),
      .cin  (st_cin[k]),
      .op   (st_op[k]),
      .r    (r),
      .cout (ch_cout[k]),
      .zero (ch_zero[k])
    );

    assign ch_r[k] = WIDTH'(r);
  end

  always_comb begin : p_stage_next
    for (int k = 0; k < CC; k++) begin
      vld_d[k]  = st_vld[k];
      op_d[k]   = st_op[k];
      a_d[k]    = st_a[k];
      b_d[k]    = st_b[k];
      res_d[k]  = st_res[k] | (ch_r[k] << (k * AW));
      cy_d[k]   = ch_cout[k];
      zero_d[k] = st_zero[k] & ch_zero[k];
    end
    // The final carry leaves as a borrow for SUB; bitwise chunks already report 0.
    if (st_op[CC-1] == OP_SUB)
      cy_d[CC-1] = ~ch_cout[CC-1];
    ovf_d = ((st_op[CC-1] == OP_ADD) || (st_op[CC-1] == OP_SUB))
            && (st_a[CC-1][WIDTH-1] == (st_b[CC-1][WIDTH-1] ^ (st_op[CC-1] == OP_SUB)))
            && (res_d[CC-1][WIDTH-1] != st_a[CC-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CC; k++) begin
        vld_q[k]  <= 1'b0;
        op_q[k]   <= '0;
        cy_q[k]   <= 1'b0;
        zero_q[k] <= 1'b0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        res_q[k]  <= '0;
      end
      ovf_q <= 1'b0;
    end else if (ce) begin
      for (int k = 0; k < CC; k++) begin
        vld_q[k]  <= vld_d[k];
        op_q[k]   <= op_d[k];
        cy_q[k]   <= cy_d[k];
        zero_q[k] <= zero_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        res_q[k]  <= res_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign o_valid    = vld_q[CC-1];
  assign o_result   = res_q[CC-1];
  assign o_cout     = cy_q[CC-1];
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q[CC-1];

endmodule

// File: tb/tb_math_pipelined_alu.sv
// Bench for math_pipelined_alu: directed hand-checked vectors on an 8-bit/4-stage
// instance plus a scoreboard over that and four 5-bit instances of varying depth.
module tb_math_pipelined_alu;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       o;
    logic       z;
    int         stamp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       i_valid;
  logic [2:0] i_op;
  logic       i_cin;
  logic [7:0] I1;
  logic [7:0] I2;

  logic       mv [5];
  logic [7:0] mr [5];
  logic       mc [5];
  logic       mo [5];
  logic       mz [5];
  logic [4:0] sw_r [4];

  int w_of  [5] = '{8, 5, 5, 5, 5};
  int cc_of [5] = '{4, 1, 2, 3, 5};

  exp_t sbq [5][$];
  exp_t e_m;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop [5] = '{0, 0, 0, 0, 0};
  int   edge_cnt = 0;
  logic ce_s;
  logic       mv_prev [5];
  logic [7:0] mr_prev [5];

  always #5 clk = ~clk;

  math_pipelined_alu #(.WIDTH(8), .LATENCY(4)) u_dut8 (
    .clk(clk), .rst(rst), .ce(ce), .i_valid(i_valid), .i_op(i_op), .i_cin(i_cin),
    .I1(I1), .I2(I2), .o_valid(mv[0]), .o_result(mr[0]), .o_cout(mc[0]),
    .o_overflow(mo[0]), .o_zero(mz[0])
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 7;
    math_pipelined_alu #(.WIDTH(5), .LATENCY(LAT)) u_dut5 (
      .clk(clk), .rst(rst), .ce(ce), .i_valid(i_valid), .i_op(i_op), .i_cin(i_cin),
      .I1(I1[4:0]), .I2(I2[4:0]), .o_valid(mv[g+1]), .o_result(sw_r[g]), .o_cout(mc[g+1]),
      .o_overflow(mo[g+1]), .o_zero(mz[g+1])
    );
    assign mr[g+1] = {3'b000, sw_r[g]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers, independent of chunking.
  function automatic exp_t model(int w, logic [7:0] a8, logic [7:0] b8, logic [2:0] op, logic cin);
    exp_t e;
    int m, a, b, ci, s, sa, sb, sr, lo, hi;
    m  = 1 << w;
    a  = int'(a8) % m;
    b  = int'(b8) % m;
    ci = cin ? 1 : 0;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    lo = -(m / 2);
    hi = m / 2 - 1;
    e.c = 1'b0;
    e.o = 1'b0;
    e.stamp = 0;
    case (op)
      3'd0: begin
        s = a + b + ci;
        e.r = 8'(s % m);
        e.c = (s >= m);
        sr = sa + sb + ci;
        e.o = (sr < lo) || (sr > hi);
      end
      3'd1: begin
        s = a - b - ci;
        e.r = 8'((s + m) % m);
        e.c = (a < b + ci);
        sr = sa - sb - ci;
        e.o = (sr < lo) || (sr > hi);
      end
      3'd2:    e.r = 8'(a & b);
      3'd3:    e.r = 8'(a | b);
      default: e.r = 8'(a ^ b);
    endcase
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  // Scoreboard: push at each accepted edge, pop on each ce-qualified valid output.
  always @(posedge clk) begin
    if (!rst) begin
      ce_s = ce;
      if (ce) begin
        edge_cnt++;
        if (i_valid) begin
          for (int i = 0; i < 5; i++) begin
            e_m = model(w_of[i], I1, I2, i_op, i_cin);
            e_m.stamp = edge_cnt;
            sbq[i].push_back(e_m);
          end
        end
      end
      for (int i = 0; i < 5; i++) begin
        mv_prev[i] = mv[i];
        mr_prev[i] = mr[i];
      end
      #1;
      for (int i = 0; i < 5; i++) begin
        if (!ce_s) begin
          check($sformatf("hold_valid%0d", i), 32'(mv[i]), 32'(mv_prev[i]));
          check($sformatf("hold_result%0d", i), 32'(mr[i]), 32'(mr_prev[i]));
        end else if (mv[i]) begin
          if (sbq[i].size() == 0) begin
            check($sformatf("spurious_valid%0d", i), 32'(mv[i]), 32'd0);
          end else begin
            e_m = sbq[i].pop_front();
            n_pop[i]++;
            check($sformatf("result%0d", i), 32'(mr[i]), 32'(e_m.r));
            check($sformatf("cout%0d", i), 32'(mc[i]), 32'(e_m.c));
            check($sformatf("ovf%0d", i), 32'(mo[i]), 32'(e_m.o));
            check($sformatf("zero%0d", i), 32'(mz[i]), 32'(e_m.z));
            check($sformatf("latency%0d", i), 32'(edge_cnt - e_m.stamp + 1), 32'(cc_of[i]));
          end
        end
      end
    end
  end

  task automatic drive_dir(input string tag, input logic [2:0] op, input logic cin,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                           input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    ce = 1'b1; i_valid = 1'b1; i_op = op; i_cin = cin; I1 = a; I2 = b;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early_valid"}, 32'(mv[0]), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(mv[0]), 32'd1);
    check({tag, "_result"}, 32'(mr[0]), 32'(er));
    check({tag, "_cout"}, 32'(mc[0]), 32'(ec));
    check({tag, "_ovf"}, 32'(mo[0]), 32'(eo));
    check({tag, "_zero"}, 32'(mz[0]), 32'(ez));
  endtask

  task automatic drive_rand(input logic vld);
    i_valid = vld;
    i_op    = 3'($urandom_range(0, 7));
    i_cin   = 1'($urandom_range(0, 1));
    I1      = 8'($urandom_range(0, 255));
    I2      = 8'($urandom_range(0, 255));
  endtask

  int pop_base;

  initial begin
    rst = 1'b1; ce = 1'b0; i_valid = 1'b0; i_op = 3'd0; i_cin = 1'b0; I1 = 8'h00; I2 = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(mv[0]), 32'd0);
    check("rst_result", 32'(mr[0]), 32'd0);
    check("rst_cout", 32'(mc[0]), 32'd0);
    check("rst_ovf", 32'(mo[0]), 32'd0);
    check("rst_zero", 32'(mz[0]), 32'd0);
    rst = 1'b0;

    //         tag        op    cin   A      B      result cout ovf zero
    drive_dir("add_wrap", 3'd0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    drive_dir("sub_ovf",  3'd1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    drive_dir("sub_bin",  3'd1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive_dir("add_cin",  3'd0, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0);
    drive_dir("add_neg",  3'd0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
    drive_dir("sub_pos",  3'd1, 1'b1, 8'h05, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0);
    drive_dir("and",      3'd2, 1'b1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    drive_dir("or",       3'd3, 1'b1, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
    drive_dir("xor",      3'd4, 1'b0, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0);
    drive_dir("op6_xor",  3'd6, 1'b1, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);

    // 16 back-to-back operations
    pop_base = n_pop[0];
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      ce = 1'b1;
      drive_rand(1'b1);
    end
    @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("stream_count", 32'(n_pop[0] - pop_base), 32'd16);

    // ce and valid toggled pseudo-randomly
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      ce = 1'($urandom_range(0, 1));
      drive_rand(1'($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    ce = 1'b1; i_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("ce_drain_q", 32'(sbq[0].size()), 32'd0);

    // Asynchronous reset with three operations in flight
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      drive_rand(1'b1);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(mv[0]), 32'd0);
    check("arst_result", 32'(mr[0]), 32'd0);
    check("arst_cout", 32'(mc[0]), 32'd0);
    check("arst_ovf", 32'(mo[0]), 32'd0);
    check("arst_zero", 32'(mz[0]), 32'd0);
    check("arst_valid_w5l7", 32'(mv[4]), 32'd0);
    for (int i = 0; i < 5; i++) sbq[i].delete();
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_valid", 32'(mv[0]), 32'd0);
    drive_dir("post_rst", 3'd0, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 1'b0);

    // Exhaustive 5-bit sweep, shared across all instances
    for (int op = 0; op < 5; op++) begin
      for (int c = 0; c < 2; c++) begin
        for (int a = 0; a < 32; a++) begin
          for (int b = 0; b < 32; b++) begin
            @(negedge clk);
            ce = 1'b1; i_valid = 1'b1;
            i_op = 3'(op); i_cin = 1'(c); I1 = 8'(a); I2 = 8'(b);
          end
        end
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("final_queue%0d", i), 32'(sbq[i].size()), 32'd0);
    check("sweep_count_w5l1", 32'(n_pop[1] >= 5120), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
